// File: rtl/id_tracker_pkg.sv
// Shared types and helpers for the in-flight ID tracker.
// The round-robin search helper is only used when ID_TRACKER_RR_EN is defined.
package id_tracker_pkg;

    localparam int DEF_NUM_IDS = 8;
    localparam int DEF_ID_W    = $clog2(DEF_NUM_IDS);
    localparam int MAX_IDS     = 64;

    typedef logic [DEF_ID_W-1:0]    id_t;
    typedef logic [DEF_NUM_IDS-1:0] id_vec_t;
    typedef logic [MAX_IDS-1:0]     wide_vec_t;

    // Rotates the low 'width' bits of vec right by amt (bit amt lands at bit 0);
    // bits at and above 'width' come back as zero.
    function automatic wide_vec_t rotate_right(input wide_vec_t   vec,
                                               input int unsigned amt,
                                               input int unsigned width);
        wide_vec_t r;
        wide_vec_t sh;
        r  = '0;
        sh = '0;
        for (int unsigned i = 0; i < MAX_IDS; i++) begin
            if (i < width) begin
                sh   = vec >> ((i + amt) % width);
                r[i] = sh[0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/integer_to_one_hot.sv
// Combinational integer-to-one-hot decoder.
// Output is all-zero when i_en is low or i_value is out of range.
module integer_to_one_hot #(
    parameter  int C_WIDTH = 8,
    localparam int C_IN_W  = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1
) (
    input  logic              i_en,
    input  logic [C_IN_W-1:0] i_value,
    output logic [C_WIDTH-1:0] o_one_hot
);

    genvar gi;
    generate
        for (gi = 0; gi < C_WIDTH; gi++) begin : g_bit
            assign o_one_hot[gi] = i_en && (i_value == C_IN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/id_inflight_tracker.sv
// Tracks in-flight transaction IDs: grants free IDs, retires them in any order.
// Define ID_TRACKER_RR_EN for round-robin grant; default is lowest-index-first.
module id_inflight_tracker
    import id_tracker_pkg::*;
#(
    parameter  int NUM_IDS = 8,
    localparam int ID_W    = $clog2(NUM_IDS),
    localparam int CNT_W   = $clog2(NUM_IDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               alloc_valid,
    output logic [ID_W-1:0]    alloc_id,
    output logic [NUM_IDS-1:0] alloc_one_hot,
    input  logic               retire_valid,
    input  logic [ID_W-1:0]    retire_id,
    output logic [NUM_IDS-1:0] inflight,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               retire_err
);

    logic [NUM_IDS-1:0] r_inflight;
    logic [CNT_W-1:0]   r_count;
    logic               r_retire_err;

    logic [NUM_IDS-1:0] w_free;
    wide_vec_t          w_free_wide;
    wide_vec_t          w_search_wide;
    logic [ID_W-1:0]    w_base;
    int                 w_offset;
    int                 w_sum;
    logic [ID_W-1:0]    w_alloc_id;
    logic [NUM_IDS-1:0] w_alloc_oh;
    logic [NUM_IDS-1:0] w_retire_oh;
    logic               w_alloc_fire;
    logic               w_retire_legal;
    logic               w_retire_illegal;
    logic [NUM_IDS-1:0] w_inflight_next;

    assign w_free = ~r_inflight;

    always_comb begin
        w_free_wide                = '0;
        w_free_wide[NUM_IDS-1:0]   = w_free;
    end

`ifdef ID_TRACKER_RR_EN
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_next;

    assign w_base        = r_rr_ptr;
    assign w_search_wide = rotate_right(w_free_wide, 32'(r_rr_ptr), 32'(NUM_IDS));
    assign w_rr_next     = (w_alloc_id == ID_W'(NUM_IDS - 1)) ? '0 : w_alloc_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_alloc_fire) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`else
    assign w_base        = '0;
    assign w_search_wide = w_free_wide;
`endif

    // Find-first from bit 0 of the (possibly rotated) free vector, then undo the rotation.
    always_comb begin
        w_offset = 0;
        for (int i = MAX_IDS - 1; i >= 0; i--) begin
            if (w_search_wide[i]) begin
                w_offset = i;
            end
        end
        w_sum = int'(w_base) + w_offset;
        if (w_sum >= NUM_IDS) begin
            w_sum = w_sum - NUM_IDS;
        end
        w_alloc_id = ID_W'(w_sum);
    end

    assign alloc_valid  = |w_free;
    assign w_alloc_fire = alloc_req && alloc_valid;

    integer_to_one_hot #(.C_WIDTH(NUM_IDS)) u_alloc_dec (
        .i_en      (alloc_valid),
        .i_value   (w_alloc_id),
        .o_one_hot (w_alloc_oh)
    );

    integer_to_one_hot #(.C_WIDTH(NUM_IDS)) u_retire_dec (
        .i_en      (retire_valid),
        .i_value   (retire_id),
        .o_one_hot (w_retire_oh)
    );

    // An out-of-range id decodes to zero, so it can never match an occupied bit.
    assign w_retire_legal   = |(w_retire_oh & r_inflight);
    assign w_retire_illegal = retire_valid && !w_retire_legal;

    assign w_inflight_next = (r_inflight | (w_alloc_fire ? w_alloc_oh : '0))
                           & ~(w_retire_legal ? w_retire_oh : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight   <= '0;
            r_count      <= '0;
            r_retire_err <= 1'b0;
        end else begin
            r_inflight <= w_inflight_next;
            case ({w_alloc_fire, w_retire_legal})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_retire_illegal) begin
                r_retire_err <= 1'b1;
            end
        end
    end

    assign alloc_id      = w_alloc_id;
    assign alloc_one_hot = w_alloc_oh;
    assign inflight      = r_inflight;
    assign count         = r_count;
    assign full          = (r_count == CNT_W'(NUM_IDS));
    assign empty         = (r_count == '0);
    assign retire_err    = r_retire_err;

endmodule

// File: tb/tb_id_inflight_tracker.sv
// Directed bench for id_inflight_tracker (8-ID and 6-ID instances).
// Round-robin expectations apply when ID_TRACKER_RR_EN is defined.
module tb_id_inflight_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [2:0] alloc_id;
    logic [7:0] alloc_one_hot;
    logic       retire_valid = 1'b0;
    logic [2:0] retire_id = 3'd0;
    logic [7:0] inflight;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       retire_err;

    logic       b_alloc_req = 1'b0;
    logic       b_alloc_valid;
    logic [2:0] b_alloc_id;
    logic [5:0] b_alloc_one_hot;
    logic       b_retire_valid = 1'b0;
    logic [2:0] b_retire_id = 3'd0;
    logic [5:0] b_inflight;
    logic [2:0] b_count;
    logic       b_full;
    logic       b_empty;
    logic       b_retire_err;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    id_inflight_tracker #(.NUM_IDS(8)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_id(alloc_id),
        .alloc_one_hot(alloc_one_hot), .retire_valid(retire_valid), .retire_id(retire_id),
        .inflight(inflight), .count(count), .full(full), .empty(empty),
        .retire_err(retire_err)
    );

    id_inflight_tracker #(.NUM_IDS(6)) dut6 (
        .clk(clk), .rst(rst),
        .alloc_req(b_alloc_req), .alloc_valid(b_alloc_valid), .alloc_id(b_alloc_id),
        .alloc_one_hot(b_alloc_one_hot), .retire_valid(b_retire_valid), .retire_id(b_retire_id),
        .inflight(b_inflight), .count(b_count), .full(b_full), .empty(b_empty),
        .retire_err(b_retire_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req      = 1'b0;
        retire_valid   = 1'b0;
        b_alloc_req    = 1'b0;
        b_retire_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic retire_one(input logic [2:0] id);
        retire_valid = 1'b1;
        retire_id    = id;
        tick();
        retire_valid = 1'b0;
    endtask

    int rr_seq  [6];
    int fix_seq [6];

    initial begin
        rr_seq  = '{3, 4, 5, 6, 7, 0};
        fix_seq = '{0, 3, 4, 5, 6, 7};

        // Reset state, sampled while rst is still asserted
        #2;
        chk("rst_alloc_valid", 32'(alloc_valid), 32'd1);
        chk("rst_alloc_id", 32'(alloc_id), 32'd0);
        chk("rst_alloc_oh", 32'(alloc_one_hot), 32'h01);
        chk("rst_inflight", 32'(inflight), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(retire_err), 32'd0);
        tick();
        rst = 1'b0;
        $display("reset released, base state checked");

        // Hold alloc_req for 9 cycles: ids 0..7 then a refused request
        alloc_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_id%0d", i), 32'(alloc_id), 32'(i));
            chk($sformatf("fill_oh%0d", i), 32'(alloc_one_hot), 32'(1) << i);
            tick();
            chk($sformatf("fill_cnt%0d", i), 32'(count), 32'(i + 1));
            $display("alloc grant %0d -> inflight=%02h count=%0d", i, inflight, count);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_valid", 32'(alloc_valid), 32'd0);
        chk("fill_oh_zero", 32'(alloc_one_hot), 32'h00);
        tick();
        chk("ninth_inflight", 32'(inflight), 32'hFF);
        chk("ninth_count", 32'(count), 32'd8);
        $display("ninth request refused, inflight=%02h", inflight);

        // Full: retire 3 with alloc_req; freed id is only grantable next cycle
        retire_valid = 1'b1;
        retire_id    = 3'd3;
        chk("rt3_no_valid", 32'(alloc_valid), 32'd0);
        tick();
        retire_valid = 1'b0;
        chk("rt3_inflight", 32'(inflight), 32'hF7);
        chk("rt3_count", 32'(count), 32'd7);
        chk("rt3_regrant_id", 32'(alloc_id), 32'd3);
        chk("rt3_regrant_oh", 32'(alloc_one_hot), 32'h08);
        tick();
        alloc_req = 1'b0;
        chk("rt3_full_again", 32'(full), 32'd1);
        $display("retire 3 + alloc, regrant 3 next cycle, inflight=%02h", inflight);

        // Build 8'hA5, raise the error flag, then reset mid-cycle
        retire_one(3'd1);
        retire_one(3'd3);
        retire_one(3'd4);
        retire_one(3'd6);
        chk("a5_inflight", 32'(inflight), 32'hA5);
        chk("a5_count", 32'(count), 32'd4);
        retire_one(3'd1);
        chk("a5_err", 32'(retire_err), 32'd1);
        chk("a5_hold", 32'(inflight), 32'hA5);
        rst = 1'b1;
        #1;
        chk("async_inflight", 32'(inflight), 32'h00);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_err", 32'(retire_err), 32'd0);
        tick();
        rst = 1'b0;
        $display("async reset from inflight=a5 cleared state");

        // inflight=01: retire 0 and alloc together
        alloc_req = 1'b1;
        tick();
        chk("one_inflight", 32'(inflight), 32'h01);
        retire_valid = 1'b1;
        retire_id    = 3'd0;
        chk("swap_id", 32'(alloc_id), 32'd1);
        tick();
        alloc_req    = 1'b0;
        retire_valid = 1'b0;
        chk("swap_inflight", 32'(inflight), 32'h02);
        chk("swap_count", 32'(count), 32'd1);
        chk("swap_err", 32'(retire_err), 32'd0);
        $display("retire 0 + alloc -> id 1, inflight=%02h", inflight);

        // Illegal retires: cleared bit on the 8-ID unit, out of range on the 6-ID unit
        do_reset();
        retire_valid   = 1'b1;
        retire_id      = 3'd5;
        b_retire_valid = 1'b1;
        b_retire_id    = 3'd7;
        chk("ill_err_pre", 32'(retire_err), 32'd0);
        tick();
        retire_valid   = 1'b0;
        b_retire_valid = 1'b0;
        chk("ill_err", 32'(retire_err), 32'd1);
        chk("ill_inflight", 32'(inflight), 32'h00);
        chk("ill_count", 32'(count), 32'd0);
        chk("b_ill_err", 32'(b_retire_err), 32'd1);
        chk("b_ill_inflight", 32'(b_inflight), 32'h00);
        b_alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b_fill_id%0d", i), 32'(b_alloc_id), 32'(i));
            tick();
        end
        b_alloc_req = 1'b0;
        chk("b_full", 32'(b_full), 32'd1);
        chk("b_inflight", 32'(b_inflight), 32'h3F);
        chk("b_count", 32'(b_count), 32'd6);
        chk("b_valid", 32'(b_alloc_valid), 32'd0);
        chk("ill_err_held", 32'(retire_err), 32'd1);
        chk("b_err_held", 32'(b_retire_err), 32'd1);
        do_reset();
        chk("ill_err_cleared", 32'(retire_err), 32'd0);
        chk("b_err_cleared", 32'(b_retire_err), 32'd0);
        $display("illegal retires flagged, sticky until reset");

        // Selection policy: alloc 0,1,2, retire 0, fill, wrap
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pol_id%0d", i), 32'(alloc_id), 32'(i));
            tick();
        end
        alloc_req = 1'b0;
        retire_one(3'd0);
        chk("pol_inflight", 32'(inflight), 32'h06);
        alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef ID_TRACKER_RR_EN
            chk($sformatf("pol_seq%0d", i), 32'(alloc_id), 32'(rr_seq[i]));
`else
            chk($sformatf("pol_seq%0d", i), 32'(alloc_id), 32'(fix_seq[i]));
`endif
            tick();
            $display("policy grant step %0d -> inflight=%02h", i, inflight);
        end
        alloc_req = 1'b0;
        chk("pol_full", 32'(full), 32'd1);
        retire_one(3'd0);
        alloc_req = 1'b1;
        chk("pol_wrap_id", 32'(alloc_id), 32'd0);
        tick();
        alloc_req = 1'b0;
        chk("pol_wrap_full", 32'(full), 32'd1);
        retire_one(3'd5);
        retire_one(3'd0);
        chk("pol_de", 32'(inflight), 32'hDE);
        alloc_req = 1'b1;
`ifdef ID_TRACKER_RR_EN
        chk("pol_ptr_id", 32'(alloc_id), 32'd5);
`else
        chk("pol_ptr_id", 32'(alloc_id), 32'd0);
`endif
        tick();
        alloc_req = 1'b0;
        chk("pol_final_count", 32'(count), 32'd7);
        $display("policy final grant done, inflight=%02h", inflight);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
